// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 10**n as an unsigned integer, used to size the overflow threshold
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit pre-shift correction: adds 3 to any digit of 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Add 3 so the following left shift carries into the next digit exactly when 2*din >= 10
    always_comb begin
        dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Shift-add-3 binary-to-BCD converter, one adjust/shift per clock; BCD_SATURATE_EN clamps overflow to all nines.
// Latency: done pulses BIN_W+1 cycles after the edge that accepts start; one conversion per BIN_W+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BIN_W-1:0]           bin_in,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd_out,
    output logic                       overflow
);

    localparam int          SCR_W = DIGIT_W * DIGITS;
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned LIMIT = pow10(DIGITS);

    state_t             state_q,    state_d;
    logic [BIN_W-1:0]   shreg_q,    shreg_d;
    logic [SCR_W-1:0]   scratch_q,  scratch_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               ovf_q,      ovf_d;
    logic               done_q,     done_d;
    logic [SCR_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   result;

    // One corrector per digit of the scratch register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .dout (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Value presented to the display once the shifting is finished
    always_comb begin
`ifdef BCD_SATURATE_EN
        result = ovf_q ? {DIGITS{BCD_NINE}} : scratch_q;
`else
        result = scratch_q;
`endif
    end

    // Next-state and datapath: load on accept, adjust+shift per cycle, publish in DONE
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    shreg_d   = bin_in;
                    scratch_d = '0;
                    count_d   = CNT_W'(BIN_W);
                    ovf_d     = (64'(bin_in) >= 64'(LIMIT));
                end
            end
            SHIFT: begin
                // The bit leaving the top digit is dropped, which keeps scratch at value mod 10**DIGITS
                scratch_d = {adj[SCR_W-2:0], shreg_q[BIN_W-1]};
                shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
                count_d   = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = result;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any request in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed scenarios plus random values against an arithmetic decimal model.
// Latency: checks done arrives 15 cycles after the accepting edge.
// Backpressure: checks that start while busy is ignored and held start re-triggers.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [BIN_W-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [15:0]       bcd_out;
    logic              overflow;

    int n_chk = 0;
    int n_err = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Decimal digits of v mod 10000 (or all nines when saturating an overflow)
    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
`ifdef BCD_SATURATE_EN
        if (v >= 10000) return 16'h9999;
`endif
        t = v % 10000;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Launch one conversion and check latency, busy, result and the single-cycle done
    task automatic run_conv(input int v, input string tag);
        int lat;
        logic busy_ok;
        bin_in = BIN_W'(v);
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            cyc();
            lat++;
        end
        check({tag, "_lat"}, lat, 15);
        check({tag, "_busy"}, 32'(busy_ok), 1);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(model_bcd(v)));
        check({tag, "_ovf"}, 32'(overflow), (v >= 10000) ? 1 : 0);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        cyc();
        check({tag, "_done_width"}, 32'(done), 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int t_done[$];
        int n_done;
        int v;

        rst = 1'b1;
        start = 1'b0;
        bin_in = '0;

        // Reset state
        repeat (3) cyc();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bcd", 32'(bcd_out), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        cyc();

        // Basic conversion
        run_conv(1234, "c1234");
        repeat (3) cyc();
        check("hold_bcd", 32'(bcd_out), 32'h1234);

        // Back-to-back with start held high
        bin_in = BIN_W'(0);
        start  = 1'b1;
        cyc();
        bin_in = BIN_W'(9999);
        for (int c = 1; c <= 40 && t_done.size() < 2; c++) begin
            cyc();
            if (done) begin
                t_done.push_back(c);
                if (t_done.size() == 1) begin
                    check("b2b_first_bcd", 32'(bcd_out), 32'h0000);
                end else begin
                    check("b2b_second_bcd", 32'(bcd_out), 32'h9999);
                    check("b2b_ovf", 32'(overflow), 0);
                end
            end
        end
        start = 1'b0;
        check("b2b_count", t_done.size(), 2);
        if (t_done.size() == 2) begin
            check("b2b_first_lat", t_done[0], 15);
            check("b2b_gap", t_done[1] - t_done[0], 16);
        end
        wait_idle("b2b");
        cyc();

        // Overflow
        run_conv(16383, "c16383");
        run_conv(10000, "c10000");

        // Start pulsed while busy is ignored
        bin_in = BIN_W'(42);
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                bin_in = BIN_W'(77);
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            cyc();
            if (done) n_done++;
        end
        start = 1'b0;
        check("ign_done_count", n_done, 1);
        check("ign_bcd", 32'(bcd_out), 32'h0042);

        // Reset mid-conversion with start held
        bin_in = BIN_W'(555);
        start  = 1'b1;
        cyc();
        n_done = 0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (done) n_done++;
        end
        rst = 1'b1;
        cyc();
        check("abort_done_count", n_done, 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_bcd", 32'(bcd_out), 0);
        rst = 1'b0;
        run_conv(4321, "post_abort");

        // Random values with random idle gaps
        for (int k = 0; k < 30; k++) begin
            v = int'($urandom_range(0, 16383));
            run_conv(v, "rand");
            repeat ($urandom_range(0, 3)) cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
